// File: rtl/rtl_operand_queue_pkg.sv
// adder_pkg: shared operand types and constants for the adder/subtracter path.
package adder_pkg;
   localparam int DEF_DEPTH = 4;
   localparam int DEF_WIDTH = 32;
   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;
   typedef struct packed {
      logic [DEF_WIDTH-1:0] a;
      logic [DEF_WIDTH-1:0] b;
      logic                 mode;
   } operand_t;
endpackage

// File: rtl/rtl_operand_queue_if.sv
// rtl_operand_queue_if: producer/consumer handshake bundle around the operand queue.
interface rtl_operand_queue_if
   import adder_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
);
   logic                     in_valid;
   logic                     in_ready;
   logic [WIDTH-1:0]         in_a;
   logic [WIDTH-1:0]         in_b;
   logic                     in_mode;
   logic                     flush;
   logic [WIDTH-1:0]         a;
   logic [WIDTH-1:0]         b;
   logic                     mode;
   logic                     out_valid;
   logic                     out_ready;
   logic [$clog2(DEPTH):0]   count;
   modport master (
      output in_valid, in_a, in_b, in_mode, flush, out_ready,
      input  in_ready, a, b, mode, out_valid, count
   );
   modport slave (
      input  in_valid, in_a, in_b, in_mode, flush, out_ready,
      output in_ready, a, b, mode, out_valid, count
   );
endinterface

// File: rtl/rtl_operand_queue.sv
// rtl_operand_queue: FIFO of {a, b, mode} operand sets feeding rtl_adder_subtracter.
module rtl_operand_queue
   import adder_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int WIDTH = DEF_WIDTH
) (
   input logic                 clk,
   input logic                 rst,
   rtl_operand_queue_if.slave  q
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   operand_t       mem [DEPTH];
   operand_t       head;
   logic [AW-1:0]  wp;
   logic [AW-1:0]  rp;
   logic [AW:0]    cnt;
   logic           push;
   logic           pop;
   // flush masks both handshakes so it wins over any concurrent transfer
   always_comb begin
      q.in_ready  = cnt < FULL;
      q.out_valid = cnt != '0;
      push        = q.in_valid && q.in_ready && !q.flush;
      pop         = q.out_valid && q.out_ready && !q.flush;
      head        = q.out_valid ? mem[rp] : '0;
      q.a         = WIDTH'(head.a);
      q.b         = WIDTH'(head.b);
      q.mode      = head.mode;
      q.count     = cnt;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (q.flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (push) wp <= wp + 1'b1;
         if (pop) rp <= rp + 1'b1;
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         mem <= '{default: '0};
      else if (push)
         mem[wp] <= '{a: DEF_WIDTH'(q.in_a), b: DEF_WIDTH'(q.in_b), mode: q.in_mode};
   end
endmodule

// File: tb/tb_rtl_operand_queue.sv
// tb_rtl_operand_queue: directed table-driven check of the operand queue.
module tb_rtl_operand_queue;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int compared = 0;
   int mismatched = 0;
   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic [31:0] ib;
      logic        im;
      logic        ordy;
      logic        fl;
      logic        ev;
      logic [31:0] ea;
      logic [31:0] eb;
      logic        em;
      logic [2:0]  ec;
      logic        eir;
   } vec_t;
   vec_t tbl[$];
   rtl_operand_queue_if #(.DEPTH(4), .WIDTH(32)) q ();
   rtl_operand_queue #(.DEPTH(4), .WIDTH(32)) dut (
      .clk(clk),
      .rst(rst),
      .q(q)
   );
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", nm, idx, got, exp);
      end
   endtask
   task automatic chk_all(input int idx, input logic ev, input logic [31:0] ea, input logic [31:0] eb,
                          input logic em, input logic [2:0] ec, input logic eir);
      chk("out_valid", idx, 32'(q.out_valid), 32'(ev));
      chk("a", idx, q.a, ea);
      chk("b", idx, q.b, eb);
      chk("mode", idx, 32'(q.mode), 32'(em));
      chk("count", idx, 32'(q.count), 32'(ec));
      chk("in_ready", idx, 32'(q.in_ready), 32'(eir));
   endtask
   task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib, input logic im,
                        input logic ordy, input logic fl);
      q.in_valid  = iv;
      q.in_a      = ia;
      q.in_b      = ib;
      q.in_mode   = im;
      q.out_ready = ordy;
      q.flush     = fl;
   endtask
   function automatic vec_t v(input logic iv, input logic [31:0] ia, input logic [31:0] ib, input logic im,
                              input logic ordy, input logic fl, input logic ev, input logic [31:0] ea,
                              input logic [31:0] eb, input logic em, input logic [2:0] ec, input logic eir);
      vec_t r;
      r = '{iv, ia, ib, im, ordy, fl, ev, ea, eb, em, ec, eir};
      return r;
   endfunction
   initial begin
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk_all(100, 0, 0, 0, 0, 0, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      // no same-cycle bypass into an empty queue
      drive(1, 32'h11, 32'h12, 0, 0, 0);
      #1;
      chk("bypass_valid", 101, 32'(q.out_valid), 32'd0);
      @(posedge clk);
      @(negedge clk);
      drive(1, 32'h21, 32'h22, 1, 0, 0);
      @(posedge clk);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      chk_all(102, 1, 32'h11, 32'h12, 0, 2, 1);
      // asynchronous reset mid-cycle with two entries queued
      #2 rst = 1'b1;
      #1;
      chk_all(103, 0, 0, 0, 0, 0, 1);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 32'h55, 32'h66, 1, 0, 0);
      @(posedge clk);
      @(negedge clk);
      chk_all(104, 1, 32'h55, 32'h66, 1, 1, 1);
      drive(0, 0, 0, 0, 1, 0);
      @(posedge clk);
      @(negedge clk);
      chk_all(105, 0, 0, 0, 0, 0, 1);
      // main vector table, starting from empty
      tbl.push_back(v(1, 5, 3, 1, 0, 0,  1, 5, 3, 1, 1, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 1, 11, 1, 0, 0, 1, 1, 11, 1, 1, 1));
      tbl.push_back(v(1, 2, 12, 0, 0, 0, 1, 1, 11, 1, 2, 1));
      tbl.push_back(v(1, 3, 13, 1, 0, 0, 1, 1, 11, 1, 3, 1));
      tbl.push_back(v(1, 4, 14, 0, 0, 0, 1, 1, 11, 1, 4, 0));
      tbl.push_back(v(1, 99, 99, 1, 0, 0, 1, 1, 11, 1, 4, 0));
      tbl.push_back(v(1, 88, 88, 1, 1, 0, 1, 2, 12, 0, 3, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 0,  1, 3, 13, 1, 2, 1));
      tbl.push_back(v(1, 9, 19, 0, 1, 0, 1, 4, 14, 0, 2, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 0,  1, 9, 19, 0, 1, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
      tbl.push_back(v(1, 21, 31, 1, 0, 0, 1, 21, 31, 1, 1, 1));
      tbl.push_back(v(1, 22, 32, 1, 0, 0, 1, 21, 31, 1, 2, 1));
      tbl.push_back(v(1, 23, 33, 1, 0, 0, 1, 21, 31, 1, 3, 1));
      tbl.push_back(v(1, 7, 7, 0, 1, 1,  0, 0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 0, 1));
      for (int i = 0; i < 6; i++) begin
         tbl.push_back(v(1, 40 + i, 50 + i, 1'(i), 0, 0, 1, 40 + i, 50 + i, 1'(i), 1, 1));
         tbl.push_back(v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
      end
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].ia, tbl[i].ib, tbl[i].im, tbl[i].ordy, tbl[i].fl);
         @(posedge clk);
         @(negedge clk);
         chk_all(i, tbl[i].ev, tbl[i].ea, tbl[i].eb, tbl[i].em, tbl[i].ec, tbl[i].eir);
      end
      drive(0, 0, 0, 0, 0, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/rtl_operand_queue.md
RTL_OPERAND_QUEUE -- requirements
Module: rtl_operand_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of operand entries (power of two, >=2).
REQ-002 Parameter WIDTH, default 32, operand width in bits.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  producer offers an operand set.
REQ-006 in_ready  output  1  queue can accept an operand set this cycle.
REQ-007 in_a  input  WIDTH  operand A from producer.
REQ-008 in_b  input  WIDTH  operand B from producer.
REQ-009 in_mode  input  1  operation select from producer (0 add, 1 subtract).
REQ-010 flush  input  1  synchronous discard of all queued entries.
REQ-011 a  output  WIDTH  head operand A to the downstream adder/subtracter.
REQ-012 b  output  WIDTH  head operand B to the downstream adder/subtracter.
REQ-013 mode  output  1  head operation select to the downstream adder/subtracter.
REQ-014 out_valid  output  1  a, b, mode carry a valid head entry.
REQ-015 out_ready  input  1  consumer accepts the head entry this cycle.
REQ-016 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-017 Push SHALL occur on a posedge when in_valid && in_ready; in_ready SHALL equal (count < DEPTH).
REQ-018 Pop SHALL occur on a posedge when out_valid && out_ready; out_valid SHALL equal (count != 0).
REQ-019 Entries SHALL leave in arrival order (FIFO); a, b, mode SHALL present the oldest entry.
REQ-020 Latency: an entry pushed into an empty queue SHALL appear on a/b/mode with out_valid high the following cycle; no same-cycle bypass.
REQ-021 When out_valid is low, a, b, mode SHALL be driven to 0.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-023 When full, in_ready SHALL be low even if a pop occurs that cycle (no full pass-through).
REQ-024 When empty, out_ready SHALL be ignored; count SHALL never underflow or exceed DEPTH.
REQ-025 Read and write pointers SHALL wrap from DEPTH-1 to 0.
REQ-026 flush SHALL take priority over push and pop: next cycle count=0, pointers=0, out_valid=0, in_ready=1; a concurrent in_valid is discarded.
REQ-027 Payload held in stable entries SHALL not change while the entry is queued; in_a/in_b/in_mode are sampled only at push.
REQ-028 Arithmetic on operands SHALL NOT be performed here; width of a, b equals WIDTH exactly.

Reset
REQ-029 rst high SHALL immediately clear count, read and write pointers, and all storage entries to 0, independent of clk.
REQ-030 During and immediately after reset: out_valid=0, a=0, b=0, mode=0, in_ready=1, count=0.
REQ-031 Reset asserted mid-transfer SHALL discard all queued entries; first push after rst deasserts behaves as push into empty.

Structure
REQ-032 Shared package adder_pkg SHALL hold typedef operand_t (packed struct: a, b, mode), the default DEPTH and WIDTH constants, and the mode encodings ADD=0, SUB=1.
REQ-033 Storage SHALL be an array of operand_t inside this module; no sub-module is required.
REQ-034 Downstream instance rtl_adder_subtracter SHALL connect by matching port names a, b, mode.

Verification
REQ-035 Reset: assert rst mid-cycle with 2 entries queued -> count=0, out_valid=0, a=b=0 immediately, in_ready=1.
REQ-036 Single transfer: push a=5, b=3, mode=1 into empty, out_ready=0 -> next cycle out_valid=1, a=5, b=3, mode=1, count=1.
REQ-037 Fill: push 4 sets (a=1..4) with out_ready=0 -> count=4, in_ready=0; fifth in_valid ignored; pop order a=1,2,3,4.
REQ-038 Concurrent: count=2, push a=9 and pop same cycle -> count stays 2, head advances to next entry, a=9 emerges after it.
REQ-039 Full plus pop: count=4, in_valid=1, out_ready=1 -> no push, count=3, in_ready=1 next cycle.
REQ-040 Flush: count=3, flush=1 with in_valid=1 (a=7) -> next cycle count=0, out_valid=0; a=7 never emerges; pointer wrap checked after 6 further push/pop pairs.
